io_arbiter: RTL and testbench

Two-master scheduler for the single memory-mapped IO port of the IO block (segment queue, LEDs, blink timer, A/B/TEST inputs). It shares that port between the CPU data path (master 0) and the debug/loader master (master 1) with round-robin arbitration. Every write is issued as an exactly-one-cycle strobe, so one store enqueues exactly one segment-queue entry however long a master holds its request. Read data is captured and returned with a one-cycle acknowledge.

---
 rtl/io_arbiter_pkg.sv | 25 ++
 rtl/io_arbiter_rr_sel2.sv | 27 ++
 rtl/io_arbiter.sv | 128 ++++++++++++
 tb/tb_io_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// io_arbiter_pkg : shared state encodings and master indices for io_arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package io_arbiter_pkg;

    localparam logic [1:0] IO_ARB_IDLE   = 2'd0;
    localparam logic [1:0] IO_ARB_ACCESS = 2'd1;
    localparam logic [1:0] IO_ARB_RESP   = 2'd2;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DBG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = IO_ARB_IDLE,
        ST_ACCESS = IO_ARB_ACCESS,
        ST_RESP   = IO_ARB_RESP
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/io_arbiter_rr_sel2.sv
// ---------------------------------------------------------------------------
// rr_sel2 : two-way round-robin select; prio breaks ties
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rr_sel2
    import io_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       sel
);

    always_comb begin
        sel = MST_CPU;
        if (req == 2'b11) begin
            sel = prio;
        end else if (req[1]) begin
            sel = MST_DBG;
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_arbiter.sv
// ---------------------------------------------------------------------------
// io_arbiter : round-robin sharing of the IO port between CPU and debug master
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module io_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              io_we,
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_data,
    input  logic [DATA_W-1:0] io_read_data,
    output logic              busy
);

    arb_state_t        state;
    logic              owner;
    logic              prio;
    logic              rr_win;
    logic              pick;
    logic              other_req;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;

    rr_sel2 u_rr_sel2 (
        .req  ({m1_req, m0_req}),
        .prio (prio),
        .sel  (rr_win)
    );

    // From RESP only the non-owner may be loaded; its own req is still high.
    always_comb begin
        other_req = (owner == MST_DBG) ? m0_req : m1_req;
        pick      = (state == ST_RESP) ? ~owner : rr_win;
        pick_we   = (pick == MST_DBG) ? m1_we    : m0_we;
        pick_addr = (pick == MST_DBG) ? m1_addr  : m0_addr;
        pick_data = (pick == MST_DBG) ? m1_wdata : m0_wdata;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            owner    <= MST_CPU;
            prio     <= MST_CPU;
            io_we    <= 1'b0;
            io_addr  <= '0;
            io_data  <= '0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (m0_req || m1_req) begin
                        io_we   <= pick_we;
                        io_addr <= pick_addr;
                        io_data <= pick_data;
                        owner   <= pick;
                        prio    <= ~pick;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    io_we <= 1'b0;
                    if (!io_we) begin
                        if (owner == MST_DBG) begin
                            m1_rdata <= io_read_data;
                        end else begin
                            m0_rdata <= io_read_data;
                        end
                    end
                    if (owner == MST_DBG) begin
                        m1_ack <= 1'b1;
                    end else begin
                        m0_ack <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (other_req) begin
                        io_we   <= pick_we;
                        io_addr <= pick_addr;
                        io_data <= pick_data;
                        owner   <= pick;
                        prio    <= ~pick;
                        state   <= ST_ACCESS;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    io_we <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_arbiter : scoreboard bench for io_arbiter with a small IO block model
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_io_arbiter;

    localparam logic [31:0] IO_LED_ADDR = 32'h0000_0010;
    localparam logic [31:0] IO_SEG_ADDR = 32'h0000_0020;
    localparam logic [31:0] IO_A_ADDR   = 32'h0000_0030;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        io_we;
    logic [31:0] io_addr, io_data, io_read_data;
    logic        busy;

    always #5 clk = ~clk;

    io_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .io_we(io_we), .io_addr(io_addr), .io_data(io_data),
        .io_read_data(io_read_data), .busy(busy)
    );

    typedef struct { logic mst; logic we; logic [31:0] addr; logic [31:0] data; logic [31:0] rdata; } exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; int cyc; } acc_t;
    typedef struct { logic mst; logic [31:0] rdata; int cyc; } ack_t;

    exp_t        exp_q[$];
    acc_t        obs_acc[$];
    ack_t        obs_ack[$];
    logic [31:0] seg_q[$];
    logic [31:0] led_reg  = '0;
    logic [31:0] ab_input = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          we_cnt = 0;
    int          cyc = 0;

    // IO block: writes land on negedge, reads are combinational
    always @(negedge clk) begin
        if (io_we) begin
            if (io_addr == IO_LED_ADDR) led_reg <= io_data;
            if (io_addr == IO_SEG_ADDR) seg_q.push_back(io_data);
        end
    end
    always_comb begin
        io_read_data = '0;
        if (io_addr == IO_A_ADDR)   io_read_data = ab_input;
        if (io_addr == IO_LED_ADDR) io_read_data = led_reg;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (io_we) we_cnt = we_cnt + 1;
        if (busy && !m0_ack && !m1_ack) obs_acc.push_back('{we: io_we, addr: io_addr, data: io_data, cyc: cyc});
        if (m0_ack) obs_ack.push_back('{mst: 1'b0, rdata: m0_rdata, cyc: cyc});
        if (m1_ack) obs_ack.push_back('{mst: 1'b1, rdata: m1_rdata, cyc: cyc});
    end

    task automatic drive(input int m, input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
        else        begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    // Issues n accesses back to back, holding req through each ack cycle.
    task automatic run_master(input int m, input int n, input logic we, input logic [31:0] a,
                              input logic [31:0] d0, input logic [31:0] step);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            drive(m, 1'b1, we, a, d0 + i * step);
            do begin @(negedge clk); t++; end while (!((m == 0) ? m0_ack : m1_ack) && t < 40);
            n_cmp++;
            if (((m == 0) ? m0_ack : m1_ack) !== 1'b1) begin
                n_err++;
                $display("FAIL ack_timeout m%0d access %0d: no ack within %0d cycles (required ack=1)", m, i, t);
            end
            @(posedge clk); #1;
        end
        drive(m, 1'b0, 1'b0, a, '0);
    endtask

    task automatic pop_pair(output acc_t a, output ack_t k, output bit got);
        got = (obs_acc.size() > 0) && (obs_ack.size() > 0);
        if (got) begin a = obs_acc.pop_front(); k = obs_ack.pop_front(); end
    endtask

    task automatic clear_obs;
        obs_acc.delete(); obs_ack.delete(); seg_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({io_we, io_addr, io_data, m0_ack, m1_ack, m0_rdata, m1_rdata, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h ack=%b%b rd0=%h rd1=%h busy=%b required all 0",
                     io_we, io_addr, io_data, m1_ack, m0_ack, m0_rdata, m1_rdata, busy);
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b required 0", busy); end
        clear_obs();
    endtask

    task automatic test_cpu_write;
        acc_t a; ack_t k; bit got; exp_t e; int t0; int w0;
        clear_obs();
        exp_q.push_back('{mst: 1'b0, we: 1'b1, addr: IO_LED_ADDR, data: 32'h0000_A5A5, rdata: '0});
        @(posedge clk); #1;
        t0 = cyc; w0 = we_cnt;
        run_master(0, 1, 1'b1, IO_LED_ADDR, 32'h0000_A5A5, 0);
        repeat (6) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        pop_pair(a, k, got);
        n_cmp++;
        if (!got || {a.we, a.addr, a.data, k.mst} !== {e.we, e.addr, e.data, e.mst}) begin
            n_err++;
            $display("FAIL cpu_write_access: got=%b we=%b addr=%h data=%h mst=%b required we=1 addr=%h data=%h mst=0",
                     got, a.we, a.addr, a.data, k.mst, e.addr, e.data);
        end
        n_cmp++;
        if (a.cyc !== t0 + 1 || k.cyc !== t0 + 2) begin
            n_err++;
            $display("FAIL cpu_write_latency: access@%0d ack@%0d required %0d/%0d", a.cyc, k.cyc, t0 + 1, t0 + 2);
        end
        n_cmp++;
        if (we_cnt - w0 !== 1 || obs_acc.size() !== 0) begin
            n_err++;
            $display("FAIL cpu_write_once: strobes=%0d extra_access=%0d required 1/0", we_cnt - w0, obs_acc.size());
        end
        n_cmp++;
        if (led_reg !== 32'h0000_A5A5) begin n_err++; $display("FAIL led_value: %h required 0000a5a5", led_reg); end
    endtask

    task automatic test_single_read;
        acc_t a; ack_t k; bit got; exp_t e; int t0;
        clear_obs();
        ab_input = 32'h0000_003C;
        exp_q.push_back('{mst: 1'b1, we: 1'b0, addr: IO_A_ADDR, data: '0, rdata: 32'h0000_003C});
        @(posedge clk); #1;
        t0 = cyc;
        run_master(1, 1, 1'b0, IO_A_ADDR, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        pop_pair(a, k, got);
        n_cmp++;
        if (!got || {a.we, a.addr, k.mst, k.rdata} !== {e.we, e.addr, e.mst, e.rdata}) begin
            n_err++;
            $display("FAIL read_m1: got=%b we=%b addr=%h mst=%b rdata=%h required we=0 addr=%h mst=1 rdata=%h",
                     got, a.we, a.addr, k.mst, k.rdata, e.addr, e.rdata);
        end
        n_cmp++;
        if (k.cyc !== t0 + 2) begin n_err++; $display("FAIL read_latency: ack@%0d required %0d", k.cyc, t0 + 2); end
        n_cmp++;
        if (m1_rdata !== 32'h0000_003C || m0_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL read_rdata_regs: m1_rdata=%h m0_rdata=%h required 0000003c/00000000", m1_rdata, m0_rdata);
        end
    endtask

    task automatic test_contention;
        acc_t a; ack_t k; bit got; exp_t e; int t0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        clear_obs();
        exp_q.push_back('{mst: 1'b0, we: 1'b1, addr: IO_SEG_ADDR, data: 32'h0000_0011, rdata: '0});
        exp_q.push_back('{mst: 1'b1, we: 1'b1, addr: IO_SEG_ADDR, data: 32'h0000_0022, rdata: '0});
        @(posedge clk); #1;
        t0 = cyc;
        fork
            run_master(0, 1, 1'b1, IO_SEG_ADDR, 32'h0000_0011, 0);
            run_master(1, 1, 1'b1, IO_SEG_ADDR, 32'h0000_0022, 0);
        join
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            pop_pair(a, k, got);
            n_cmp++;
            if (!got || {a.we, a.addr, a.data, k.mst} !== {e.we, e.addr, e.data, e.mst} || a.cyc !== t0 + 1 + 2 * i) begin
                n_err++;
                $display("FAIL contention_grant%0d: got=%b mst=%b data=%h access@%0d required mst=%b data=%h access@%0d",
                         i, got, k.mst, a.data, a.cyc, e.mst, e.data, t0 + 1 + 2 * i);
            end
        end
        n_cmp++;
        if (seg_q.size() !== 2 || seg_q[0] !== 32'h11 || seg_q[1] !== 32'h22) begin
            n_err++;
            $display("FAIL contention_seg_queue: size=%0d required 2 entries 11,22", seg_q.size());
        end
    endtask

    task automatic test_fairness;
        acc_t a; ack_t k; bit got; exp_t e; int prev_ack;
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{mst: 1'b0, we: 1'b1, addr: IO_SEG_ADDR, data: 32'h100 + i, rdata: '0});
            exp_q.push_back('{mst: 1'b1, we: 1'b1, addr: IO_SEG_ADDR, data: 32'h200 + i, rdata: '0});
        end
        @(posedge clk); #1;
        fork
            run_master(0, 4, 1'b1, IO_SEG_ADDR, 32'h100, 1);
            run_master(1, 4, 1'b1, IO_SEG_ADDR, 32'h200, 1);
        join
        repeat (3) @(posedge clk);
        #1;
        prev_ack = -1;
        for (int i = 0; i < 8; i++) begin
            e = exp_q.pop_front();
            pop_pair(a, k, got);
            n_cmp++;
            if (!got || {k.mst, a.data} !== {e.mst, e.data} || (prev_ack >= 0 && k.cyc !== prev_ack + 2)) begin
                n_err++;
                $display("FAIL fairness_grant%0d: got=%b mst=%b data=%h ack@%0d required mst=%b data=%h ack@%0d",
                         i, got, k.mst, a.data, k.cyc, e.mst, e.data, prev_ack + 2);
            end
            prev_ack = k.cyc;
        end
    endtask

    task automatic test_held_request;
        int w0;
        clear_obs();
        @(posedge clk); #1;
        w0 = we_cnt;
        run_master(0, 1, 1'b1, IO_SEG_ADDR, 32'h0000_0077, 0);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++;
        if (we_cnt - w0 !== 1 || obs_acc.size() !== 1 || seg_q.size() !== 1) begin
            n_err++;
            $display("FAIL held_request: strobes=%0d accesses=%0d seg_entries=%0d required 1/1/1",
                     we_cnt - w0, obs_acc.size(), seg_q.size());
        end
    endtask

    task automatic test_reset_mid_access;
        int t = 0;
        clear_obs();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, IO_LED_ADDR, 32'h0000_BEEF);
        do begin @(negedge clk); t++; end while (!(busy && io_we) && t < 20);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({io_we, io_addr, io_data, m0_ack, m1_ack, m0_rdata, m1_rdata, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_access: we=%b addr=%h data=%h ack=%b%b busy=%b required all 0 (wait=%0d)",
                     io_we, io_addr, io_data, m1_ack, m0_ack, busy, t);
        end
        repeat (2) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_ack.size() !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_ack: acks=%0d busy=%b required 0/0", obs_ack.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_write();
        test_single_read();
        test_contention();
        test_fairness();
        test_held_request();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
